frame_buffer_manager: RTL and testbench

Parametrised N-way frame buffer allocator between the camera capture path (writer) and the LCD/CPU consumer (reader). It owns buffer bookkeeping for NUM_BUFFERS equal-size frames in SDRAM. It hands the writer a free buffer base address after each completed frame and presents the oldest completed frame to the reader until released. It supersedes the fixed double-buffer current-frame/read-done handshake with configurable depth, a selectable overflow policy, drop accounting and flush.

---
 rtl/frame_buf_pkg.sv | 21 ++
 rtl/frame_index_fifo.sv | 69 ++++++
 rtl/frame_buffer_manager.sv | 161 ++++++++++++++++
 tb/tb_frame_buffer_manager.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/frame_buf_pkg.sv
// rtl/frame_buf_pkg.sv - shared constants and width helpers for the frame buffer manager
package frame_buf_pkg;

  localparam logic DROP_NEWEST      = 1'b0;
  localparam logic OVERWRITE_OLDEST = 1'b1;

  function automatic int unsigned fb_clog2(input int unsigned n);
    int unsigned w;
    w = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) w = i + 1;
    end
    return w;
  endfunction

  // Index width never drops below one bit so degenerate depths still get a port.
  function automatic int unsigned fb_idx_width(input int unsigned n);
    return (fb_clog2(n) < 1) ? 1 : fb_clog2(n);
  endfunction

endpackage

// File: rtl/frame_index_fifo.sv
// rtl/frame_index_fifo.sv - ready-frame index FIFO with flush and occupancy mask
module frame_index_fifo
  import frame_buf_pkg::*;
#(
  parameter int unsigned NUM_BUFFERS = 3,
  parameter int unsigned IW          = 2
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_push,
  input  logic [IW-1:0]          i_push_idx,
  input  logic                   i_pop,
  input  logic                   i_flush,
  output logic [IW-1:0]          o_head,
  output logic [IW:0]            o_count,
  output logic [NUM_BUFFERS-1:0] o_mask
);

  localparam int unsigned DEPTH = NUM_BUFFERS - 1;
  localparam int unsigned PW    = fb_idx_width(DEPTH);

  logic [IW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_rptr;
  logic [PW-1:0] r_wptr;
  logic [IW:0]   r_count;
  logic [IW:0]   w_count_n;
  logic [PW-1:0] w_slot;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    w_count_n = i_flush ? '0 : r_count;
    if (i_pop && !i_flush) w_count_n = w_count_n - (IW+1)'(1);
    if (i_push)            w_count_n = w_count_n + (IW+1)'(1);
  end

  // Flush drops every entry by snapping the read pointer onto the write pointer.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push)       r_wptr <= next_ptr(r_wptr);
      if (i_flush)      r_rptr <= r_wptr;
      else if (i_pop)   r_rptr <= next_ptr(r_rptr);
      r_count <= w_count_n;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wptr] <= i_push_idx;
  end

  always_comb begin
    o_mask = '0;
    w_slot = r_rptr;
    for (int k = 0; k < int'(DEPTH); k++) begin
      if (k < int'(r_count)) o_mask[r_mem[w_slot]] = 1'b1;
      w_slot = next_ptr(w_slot);
    end
  end

  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/frame_buffer_manager.sv
// rtl/frame_buffer_manager.sv - N-way frame buffer allocator between capture writer and display reader
module frame_buffer_manager
  import frame_buf_pkg::*;
#(
  parameter int unsigned            NUM_BUFFERS  = 3,
  parameter int unsigned            ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR    = '0,
  parameter logic [ADDR_WIDTH-1:0]  FRAME_STRIDE = 32'h0002_5800,
  localparam int unsigned           IW           = fb_idx_width(NUM_BUFFERS)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_wr_frame_done,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic                  o_rd_valid,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  input  logic                  i_rd_done,
  output logic                  o_frame_rdy_irq,
  input  logic                  i_latest_mode,
  input  logic                  i_flush,
  output logic [IW:0]           o_ready_count,
  output logic [15:0]           o_drop_count
);

  localparam logic [64:0] SPAN = 65'(BASE_ADDR) + 65'(NUM_BUFFERS) * 65'(FRAME_STRIDE);

  if (NUM_BUFFERS < 2 || NUM_BUFFERS > 8) begin : g_bad_count
    $error("frame_buffer_manager: NUM_BUFFERS must be 2..8");
  end
  if (SPAN > (65'd1 << ADDR_WIDTH)) begin : g_bad_span
    $error("frame_buffer_manager: buffers exceed the address space");
  end

  logic [IW-1:0]          r_wr_idx, r_rd_idx;
  logic                   r_rd_valid, r_irq;
  logic [NUM_BUFFERS-1:0] r_free_mask;
  logic [15:0]            r_drop_count;
  logic [ADDR_WIDTH-1:0]  r_wr_addr, r_rd_addr;

  logic [IW-1:0]          w_fifo_head, w_free_idx, w_wr_idx_n, w_rd_idx_n;
  logic [IW:0]            w_fifo_count;
  logic [NUM_BUFFERS-1:0] w_fifo_mask, w_free_avail, w_free_n;
  logic                   w_free_any, w_rd_pop, w_wr_pop, w_push, w_drop;
  logic                   w_rd_valid_n, w_irq_n, w_own_ok;
  logic [2:0]             w_hits;
  logic [IW:0]            w_queued;

  function automatic logic [ADDR_WIDTH-1:0] idx_addr(input logic [IW-1:0] idx);
    logic [63:0] v;
    v = 64'(BASE_ADDR) + 64'(idx) * 64'(FRAME_STRIDE);
    return v[ADDR_WIDTH-1:0];
  endfunction

  frame_index_fifo #(.NUM_BUFFERS(NUM_BUFFERS), .IW(IW)) u_ready_fifo (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_push     (w_push),
    .i_push_idx (r_wr_idx),
    .i_pop      (w_rd_pop | w_wr_pop),
    .i_flush    (i_flush),
    .o_head     (w_fifo_head),
    .o_count    (w_fifo_count),
    .o_mask     (w_fifo_mask)
  );

  // A flush hands its entries back first, so a same-cycle write completion can use them.
  assign w_free_avail = r_free_mask | (i_flush ? w_fifo_mask : '0);

  always_comb begin
    w_free_any = 1'b0;
    w_free_idx = '0;
    for (int i = int'(NUM_BUFFERS) - 1; i >= 0; i--) begin
      if (w_free_avail[i]) begin
        w_free_any = 1'b1;
        w_free_idx = IW'(i);
      end
    end
  end

  always_comb begin
    w_rd_pop     = !r_rd_valid && (w_fifo_count != '0) && !i_flush;
    w_wr_idx_n   = r_wr_idx;
    w_push       = 1'b0;
    w_wr_pop     = 1'b0;
    w_drop       = 1'b0;
    w_free_n     = w_free_avail;
    w_rd_idx_n   = r_rd_idx;
    w_rd_valid_n = r_rd_valid;
    w_irq_n      = 1'b0;
    if (i_wr_frame_done) begin
      if (w_free_any) begin
        w_push               = 1'b1;
        w_wr_idx_n           = w_free_idx;
        w_free_n[w_free_idx] = 1'b0;
      end else if (i_latest_mode == OVERWRITE_OLDEST && w_fifo_count != '0 && !w_rd_pop) begin
        w_push     = 1'b1;
        w_wr_pop   = 1'b1;
        w_wr_idx_n = w_fifo_head;
        w_drop     = 1'b1;
      end else begin
        w_drop = 1'b1;
      end
    end
    // The released buffer joins the free set only after this cycle's writer decision.
    if (i_rd_done && r_rd_valid) begin
      w_free_n[r_rd_idx] = 1'b1;
      w_rd_valid_n       = 1'b0;
    end else if (w_rd_pop) begin
      w_rd_idx_n   = w_fifo_head;
      w_rd_valid_n = 1'b1;
      w_irq_n      = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_idx     <= '0;
      r_rd_idx     <= '0;
      r_rd_valid   <= 1'b0;
      r_irq        <= 1'b0;
      r_free_mask  <= ~NUM_BUFFERS'(1);
      r_drop_count <= '0;
      r_wr_addr    <= BASE_ADDR;
      r_rd_addr    <= BASE_ADDR;
    end else begin
      r_wr_idx     <= w_wr_idx_n;
      r_rd_idx     <= w_rd_idx_n;
      r_rd_valid   <= w_rd_valid_n;
      r_irq        <= w_irq_n;
      r_free_mask  <= w_free_n;
      r_wr_addr    <= idx_addr(w_wr_idx_n);
      r_rd_addr    <= idx_addr(w_rd_idx_n);
      if (w_drop) r_drop_count <= r_drop_count + 16'd1;
    end
  end

  always_comb begin
    w_own_ok = 1'b1;
    w_hits   = '0;
    w_queued = '0;
    for (int i = 0; i < int'(NUM_BUFFERS); i++) begin
      w_hits = 3'(r_wr_idx == IW'(i)) + 3'(r_rd_valid && r_rd_idx == IW'(i))
             + 3'(w_fifo_mask[i]) + 3'(r_free_mask[i]);
      if (w_hits != 3'd1) w_own_ok = 1'b0;
      w_queued = w_queued + (IW+1)'(w_fifo_mask[i]);
    end
    if (w_queued != w_fifo_count) w_own_ok = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) assert (w_own_ok) else $error("frame_buffer_manager: buffer ownership broken");
  end

  assign o_wr_addr       = r_wr_addr;
  assign o_rd_valid      = r_rd_valid;
  assign o_rd_addr       = r_rd_addr;
  assign o_frame_rdy_irq = r_irq;
  assign o_ready_count   = w_fifo_count;
  assign o_drop_count    = r_drop_count;

endmodule

// File: tb/tb_frame_buffer_manager.sv
// tb/tb_frame_buffer_manager.sv - scoreboard bench for frame_buffer_manager at N=3 and N=4
module tb_frame_buffer_manager;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst3, wr3, rdd3, lm3, fl3, rv3, irq3;
  logic [31:0] wa3, ra3;
  logic [2:0]  rc3;
  logic [15:0] dc3;
  logic        rst4, wr4, rdd4, lm4, fl4, rv4, irq4;
  logic [31:0] wa4, ra4;
  logic [2:0]  rc4;
  logic [15:0] dc4;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] q3[$];
  logic [31:0] q4[$];
  bit mon4_en = 1'b1;
  logic prev_irq3 = 1'b0;
  logic prev_irq4 = 1'b0;

  frame_buffer_manager #(.NUM_BUFFERS(3)) dut3 (
    .i_clk(clk), .i_reset(rst3), .i_wr_frame_done(wr3), .o_wr_addr(wa3),
    .o_rd_valid(rv3), .o_rd_addr(ra3), .i_rd_done(rdd3), .o_frame_rdy_irq(irq3),
    .i_latest_mode(lm3), .i_flush(fl3), .o_ready_count(rc3), .o_drop_count(dc3)
  );

  frame_buffer_manager #(.NUM_BUFFERS(4)) dut4 (
    .i_clk(clk), .i_reset(rst4), .i_wr_frame_done(wr4), .o_wr_addr(wa4),
    .o_rd_valid(rv4), .o_rd_addr(ra4), .i_rd_done(rdd4), .o_frame_rdy_irq(irq4),
    .i_latest_mode(lm4), .i_flush(fl4), .o_ready_count(rc4), .o_drop_count(dc4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst3 && irq3) begin
      chk("dut3_irq_single_cycle", 32'(prev_irq3), 32'd0);
      if (q3.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL dut3_unexpected_frame: rd_addr 0x%0h, expected no frame", ra3);
      end else begin
        chk("dut3_irq_rd_addr", ra3, q3.pop_front());
        chk("dut3_irq_rd_valid", 32'(rv3), 32'd1);
      end
    end
    prev_irq3 = irq3;
  end

  always @(negedge clk) begin
    if (!rst4 && irq4 && mon4_en) begin
      if (q4.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL dut4_unexpected_frame: rd_addr 0x%0h, expected no frame", ra4);
      end else begin
        chk("dut4_irq_rd_addr", ra4, q4.pop_front());
        chk("dut4_irq_single_cycle", 32'(prev_irq4), 32'd0);
      end
    end
    prev_irq4 = irq4;
  end

  task automatic pulse3(input logic w, input logic r, input logic f);
    wr3 = w; rdd3 = r; fl3 = f;
    @(negedge clk);
    wr3 = 1'b0; rdd3 = 1'b0; fl3 = 1'b0;
  endtask

  task automatic pulse4(input logic w, input logic r, input logic f);
    wr4 = w; rdd4 = r; fl4 = f;
    @(negedge clk);
    wr4 = 1'b0; rdd4 = 1'b0; fl4 = 1'b0;
  endtask

  initial begin
    logic legal;
    rst3 = 1'b1; wr3 = 1'b0; rdd3 = 1'b0; lm3 = 1'b0; fl3 = 1'b0;
    rst4 = 1'b1; wr4 = 1'b0; rdd4 = 1'b0; lm4 = 1'b0; fl4 = 1'b0;
    repeat (3) @(negedge clk);
    rst3 = 1'b0; rst4 = 1'b0;

    chk("reset_wr_addr", wa3, 32'h0);
    chk("reset_rd_valid", 32'(rv3), 32'd0);
    chk("reset_ready_count", 32'(rc3), 32'd0);
    chk("reset_drop_count", 32'(dc3), 32'd0);
    chk("reset_irq", 32'(irq3), 32'd0);

    // Drop-newest: reader never releases buffer 0.
    q3.push_back(32'h0);
    pulse3(1, 0, 0);
    chk("drop_wr1_wr_addr", wa3, 32'h25800);
    chk("drop_wr1_ready", 32'(rc3), 32'd1);
    @(negedge clk);
    chk("drop_acquire_rd_valid", 32'(rv3), 32'd1);
    chk("drop_acquire_ready", 32'(rc3), 32'd0);
    pulse3(1, 0, 0);
    chk("drop_wr2_wr_addr", wa3, 32'h4B000);
    chk("drop_wr2_ready", 32'(rc3), 32'd1);
    pulse3(1, 0, 0);
    chk("drop_wr3_wr_addr", wa3, 32'h4B000);
    chk("drop_wr3_drop", 32'(dc3), 32'd1);
    pulse3(1, 0, 0);
    chk("drop_wr4_wr_addr", wa3, 32'h4B000);
    chk("drop_wr4_drop", 32'(dc3), 32'd2);
    chk("drop_wr4_ready", 32'(rc3), 32'd1);

    // Release and completion together with no free buffer: write is dropped.
    q3.push_back(32'h25800);
    pulse3(1, 1, 0);
    chk("same_cycle_drop", 32'(dc3), 32'd3);
    chk("same_cycle_rd_valid", 32'(rv3), 32'd0);
    chk("same_cycle_wr_addr", wa3, 32'h4B000);
    @(negedge clk);
    chk("same_cycle_reacquire", 32'(rv3), 32'd1);
    pulse3(1, 0, 0);
    chk("released_idx_allocated", wa3, 32'h0);
    chk("released_idx_ready", 32'(rc3), 32'd1);
    chk("released_idx_drop", 32'(dc3), 32'd3);

    // Mid-operation reset, then overwrite-oldest.
    rst3 = 1'b1;
    @(negedge clk);
    rst3 = 1'b0; lm3 = 1'b1;
    chk("midreset_rd_valid", 32'(rv3), 32'd0);
    chk("midreset_drop", 32'(dc3), 32'd0);
    chk("midreset_wr_addr", wa3, 32'h0);
    q3.push_back(32'h0);
    pulse3(1, 0, 0);
    @(negedge clk);
    pulse3(1, 0, 0);
    chk("latest_wr2_wr_addr", wa3, 32'h4B000);
    pulse3(1, 0, 0);
    chk("latest_wr3_swap", wa3, 32'h25800);
    chk("latest_wr3_drop", 32'(dc3), 32'd1);
    pulse3(1, 0, 0);
    chk("latest_wr4_swap", wa3, 32'h4B000);
    chk("latest_wr4_drop", 32'(dc3), 32'd2);
    chk("latest_wr4_ready", 32'(rc3), 32'd1);
    q3.push_back(32'h25800);
    pulse3(0, 1, 0);
    chk("latest_release_gap", 32'(rv3), 32'd0);
    @(negedge clk);
    chk("latest_reacquire_ready", 32'(rc3), 32'd0);
    @(negedge clk);
    chk("dut3_frames_delivered", 32'(q3.size()), 32'd0);

    // Flush at N=4 with two frames queued.
    q4.push_back(32'h0);
    pulse4(1, 0, 0);
    @(negedge clk);
    pulse4(1, 0, 0);
    pulse4(1, 0, 0);
    chk("n4_prefill_ready", 32'(rc4), 32'd2);
    chk("n4_prefill_wr_addr", wa4, 32'h70800);
    pulse4(0, 0, 1);
    chk("flush_ready", 32'(rc4), 32'd0);
    chk("flush_rd_valid", 32'(rv4), 32'd1);
    chk("flush_rd_addr", ra4, 32'h0);
    chk("flush_no_drop", 32'(dc4), 32'd0);
    pulse4(1, 0, 0);
    chk("flush_free1_wr_addr", wa4, 32'h25800);
    pulse4(1, 0, 0);
    chk("flush_free2_wr_addr", wa4, 32'h4B000);
    chk("flush_free2_ready", 32'(rc4), 32'd2);
    chk("flush_free2_drop", 32'(dc4), 32'd0);
    pulse4(1, 0, 1);
    chk("flush_with_write_wr_addr", wa4, 32'h25800);
    chk("flush_with_write_ready", 32'(rc4), 32'd1);
    chk("flush_with_write_drop", 32'(dc4), 32'd0);
    chk("dut4_frames_delivered", 32'(q4.size()), 32'd0);

    // Random pulses; the ownership assertion runs inside the design.
    mon4_en = 1'b0;
    for (int c = 0; c < 400; c++) begin
      wr4  = ($urandom_range(0, 2) == 0);
      rdd4 = ($urandom_range(0, 3) == 0);
      fl4  = ($urandom_range(0, 19) == 0);
      lm4  = $urandom_range(0, 1) == 1;
      @(negedge clk);
      legal = (wa4 % 32'h25800 == 0) && (wa4 < 32'h96000)
           && (!rv4 || ((ra4 % 32'h25800 == 0) && (ra4 < 32'h96000)))
           && (rc4 <= 3'd3);
      chk("rand_addr_range", 32'(legal), 32'd1);
    end
    wr4 = 1'b0; rdd4 = 1'b0; fl4 = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
